det_window_stat: RTL and testbench

DET_WINDOW_STAT -- requirements
Module: det_window_stat

---
 rtl/det_window_stat.sv | 145 ++++++++++++++
 tb/tb_det_window_stat.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/det_window_stat.sv
// det_window_stat: counts detector hits over a fixed window of trials and
// presents the result with a valid/ready handshake.
//
// Handshake: result_valid is high exactly while the block holds a finished
// result; the result is consumed on a rising clk edge where result_valid=1
// and result_ready=1. result_hits/result_trials stay stable while valid is
// high and keep their values afterwards until the next window completes.
module det_window_stat #(
    parameter int WINDOW       = 256,
    parameter int CNT_W        = 16,
    parameter bit AUTO_RESTART = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sample_en,
    input  logic             det_in,
    input  logic             result_ready,
    output logic             busy,
    output logic             result_valid,
    output logic [CNT_W-1:0] result_hits,
    output logic [CNT_W-1:0] result_trials,
    output logic [15:0]      window_cnt,
    output logic             dropped
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] WIN_C = WINDOW[CNT_W-1:0];

    state_t           state_q, state_d;
    logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0] trial_cnt_q, trial_cnt_d;
    logic [CNT_W-1:0] result_hits_q, result_hits_d;
    logic [CNT_W-1:0] result_trials_q, result_trials_d;
    logic [15:0]      window_cnt_q, window_cnt_d;
    logic             dropped_q, dropped_d;

    // Incremented counter values for the current trial.
    logic [CNT_W-1:0] trial_inc;
    logic [CNT_W-1:0] hit_inc;
    logic             last_trial;

    assign trial_inc  = trial_cnt_q + CNT_W'(1);
    assign hit_inc    = hit_cnt_q + {{(CNT_W-1){1'b0}}, det_in};
    assign last_trial = sample_en && (trial_inc == WIN_C);

    // State register with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (last_trial) state_d = ST_DONE;
            end
            ST_DONE: begin
                if (result_ready) state_d = AUTO_RESTART ? ST_RUN : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Moore outputs decoded from the current state.
    always_comb begin
        busy         = (state_q == ST_RUN);
        result_valid = (state_q == ST_DONE);
    end

    // Counter, result and flag next values.
    always_comb begin
        hit_cnt_d       = hit_cnt_q;
        trial_cnt_d     = trial_cnt_q;
        result_hits_d   = result_hits_q;
        result_trials_d = result_trials_q;
        window_cnt_d    = window_cnt_q;
        // Any strobe outside RUN is lost, including the handshake cycle.
        dropped_d       = dropped_q | (sample_en && (state_q != ST_RUN));
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    hit_cnt_d   = '0;
                    trial_cnt_d = '0;
                end
            end
            ST_RUN: begin
                if (sample_en) begin
                    trial_cnt_d = trial_inc;
                    hit_cnt_d   = hit_inc;
                    if (last_trial) begin
                        result_hits_d   = hit_inc;
                        result_trials_d = trial_inc;
                        window_cnt_d    = window_cnt_q + 16'd1;
                    end
                end
            end
            ST_DONE: begin
                if (result_ready && AUTO_RESTART) begin
                    hit_cnt_d   = '0;
                    trial_cnt_d = '0;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hit_cnt_q       <= '0;
            trial_cnt_q     <= '0;
            result_hits_q   <= '0;
            result_trials_q <= '0;
            window_cnt_q    <= '0;
            dropped_q       <= 1'b0;
        end else begin
            hit_cnt_q       <= hit_cnt_d;
            trial_cnt_q     <= trial_cnt_d;
            result_hits_q   <= result_hits_d;
            result_trials_q <= result_trials_d;
            window_cnt_q    <= window_cnt_d;
            dropped_q       <= dropped_d;
        end
    end

    assign result_hits   = result_hits_q;
    assign result_trials = result_trials_q;
    assign window_cnt    = window_cnt_q;
    assign dropped       = dropped_q;

endmodule

// File: tb/tb_det_window_stat.sv
// Directed bench for det_window_stat: four instances with different
// WINDOW / AUTO_RESTART settings share one set of input drivers; each test
// resets them and checks only the instance it exercises.
module tb_det_window_stat;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic sample_en = 1'b0;
    logic det_in = 1'b0;
    logic result_ready = 1'b0;

    int n_total = 0;
    int n_bad = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    // WINDOW=8, AUTO_RESTART=0
    logic        a_busy, a_valid, a_dropped;
    logic [15:0] a_hits, a_trials, a_wcnt;
    // WINDOW=4, AUTO_RESTART=1
    logic        b_busy, b_valid, b_dropped;
    logic [15:0] b_hits, b_trials, b_wcnt;
    // WINDOW=1
    logic        c_busy, c_valid, c_dropped;
    logic [15:0] c_hits, c_trials, c_wcnt;
    // WINDOW=256
    logic        d_busy, d_valid, d_dropped;
    logic [15:0] d_hits, d_trials, d_wcnt;

    det_window_stat #(.WINDOW(8), .CNT_W(16), .AUTO_RESTART(1'b0)) u_w8 (
        .clk(clk), .reset(reset), .start(start), .sample_en(sample_en),
        .det_in(det_in), .result_ready(result_ready), .busy(a_busy),
        .result_valid(a_valid), .result_hits(a_hits), .result_trials(a_trials),
        .window_cnt(a_wcnt), .dropped(a_dropped));

    det_window_stat #(.WINDOW(4), .CNT_W(16), .AUTO_RESTART(1'b1)) u_w4 (
        .clk(clk), .reset(reset), .start(start), .sample_en(sample_en),
        .det_in(det_in), .result_ready(result_ready), .busy(b_busy),
        .result_valid(b_valid), .result_hits(b_hits), .result_trials(b_trials),
        .window_cnt(b_wcnt), .dropped(b_dropped));

    det_window_stat #(.WINDOW(1), .CNT_W(16), .AUTO_RESTART(1'b0)) u_w1 (
        .clk(clk), .reset(reset), .start(start), .sample_en(sample_en),
        .det_in(det_in), .result_ready(result_ready), .busy(c_busy),
        .result_valid(c_valid), .result_hits(c_hits), .result_trials(c_trials),
        .window_cnt(c_wcnt), .dropped(c_dropped));

    det_window_stat #(.WINDOW(256), .CNT_W(16), .AUTO_RESTART(1'b0)) u_w256 (
        .clk(clk), .reset(reset), .start(start), .sample_en(sample_en),
        .det_in(det_in), .result_ready(result_ready), .busy(d_busy),
        .result_valid(d_valid), .result_hits(d_hits), .result_trials(d_trials),
        .window_cnt(d_wcnt), .dropped(d_dropped));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs set before the call are seen on this edge,
    // outputs are sampled 1ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        start = 1'b0;
        sample_en = 1'b0;
        det_in = 1'b0;
        result_ready = 1'b0;
        step();
        reset = 1'b0;
    endtask

    task automatic sample(input logic d);
        sample_en = 1'b1;
        det_in = d;
        step();
        sample_en = 1'b0;
        det_in = 1'b0;
    endtask

    logic [7:0] pat;
    int cnt;

    initial begin
        pat = 8'b1001_1001;
        #2;
        // Reset state
        check("rst_busy", a_busy, 0);
        check("rst_valid", a_valid, 0);
        check("rst_wcnt", a_wcnt, 0);
        check("rst_dropped", a_dropped, 0);
        do_reset();
        step();
        check("idle_no_start", a_busy, 0);

        // Basic window, pattern 1,0,0,1,1,0,0,1
        start = 1'b1; step(); start = 1'b0;
        check("w8_busy", a_busy, 1);
        for (int i = 0; i < 8; i++) begin
            sample(pat[i]);
            if (i == 6) check("w8_not_yet", a_valid, 0);
        end
        check("w8_valid", a_valid, 1);
        check("w8_hits", a_hits, 4);
        check("w8_trials", a_trials, 8);
        check("w8_wcnt", a_wcnt, 1);
        check("w8_busy_done", a_busy, 0);

        // Hold DONE with ready low, extra strobes dropped
        for (int i = 0; i < 20; i++) begin
            sample_en = (i == 3 || i == 9 || i == 15);
            det_in = 1'b1;
            step();
        end
        sample_en = 1'b0; det_in = 1'b0;
        check("hold_valid", a_valid, 1);
        check("hold_hits", a_hits, 4);
        check("hold_trials", a_trials, 8);
        check("hold_dropped", a_dropped, 1);
        check("hold_busy", a_busy, 0);
        result_ready = 1'b1; step(); result_ready = 1'b0;
        check("hs_valid", a_valid, 0);
        check("hs_idle_busy", a_busy, 0);
        check("hs_hits_kept", a_hits, 4);
        check("hs_wcnt", a_wcnt, 1);

        // Reset mid-window forces everything to zero immediately
        start = 1'b1; step(); start = 1'b0;
        for (int i = 0; i < 5; i++) sample(1'b1);
        check("mid_busy", a_busy, 1);
        reset = 1'b1;
        #2;
        check("rst_mid_busy", a_busy, 0);
        check("rst_mid_hits", a_hits, 0);
        check("rst_mid_trials", a_trials, 0);
        check("rst_mid_wcnt", a_wcnt, 0);
        check("rst_mid_dropped", a_dropped, 0);
        step();
        reset = 1'b0;
        step(); step();
        check("post_rst_idle", a_busy, 0);
        start = 1'b1; step(); start = 1'b0;
        for (int i = 0; i < 8; i++) sample(1'b0);
        check("zero_valid", a_valid, 1);
        check("zero_hits", a_hits, 0);
        check("zero_trials", a_trials, 8);
        check("zero_wcnt", a_wcnt, 1);

        // AUTO_RESTART, WINDOW=4, all hits, back-to-back windows
        do_reset();
        result_ready = 1'b1;
        start = 1'b1; step(); start = 1'b0;
        for (int w = 1; w <= 3; w++) begin
            for (int i = 0; i < 4; i++) sample(1'b1);
            check("ar_valid", b_valid, 1);
            check("ar_hits", b_hits, 4);
            check("ar_trials", b_trials, 4);
            check("ar_wcnt", b_wcnt, w);
            if (w == 3) sample_en = 1'b1;  // strobe on handshake edge is lost
            det_in = 1'b1;
            step();
            sample_en = 1'b0; det_in = 1'b0;
            check("ar_restart_busy", b_busy, 1);
            check("ar_restart_valid", b_valid, 0);
        end
        check("ar_hs_dropped", b_dropped, 1);
        for (int i = 0; i < 3; i++) sample(1'b1);
        check("ar_3_not_done", b_valid, 0);
        sample(1'b0);
        check("ar_w4_valid", b_valid, 1);
        check("ar_w4_hits", b_hits, 3);
        check("ar_w4_wcnt", b_wcnt, 4);
        result_ready = 1'b0;

        // WINDOW=1, start together with sample_en
        do_reset();
        start = 1'b1; sample_en = 1'b1; det_in = 1'b1;
        step();
        start = 1'b0; sample_en = 1'b0; det_in = 1'b0;
        check("w1_dropped", c_dropped, 1);
        check("w1_busy", c_busy, 1);
        check("w1_no_result", c_valid, 0);
        step();
        check("w1_still_run", c_valid, 0);
        sample(1'b1);
        check("w1_valid", c_valid, 1);
        check("w1_hits", c_hits, 1);
        check("w1_trials", c_trials, 1);
        check("w1_wcnt", c_wcnt, 1);

        // WINDOW=256, random det_in with idle gaps, 100 windows
        do_reset();
        for (int w = 0; w < 100; w++) begin
            start = 1'b1; step(); start = 1'b0;
            cnt = 0;
            for (int s = 0; s < 256; ) begin
                sample_en = ($urandom_range(0, 3) != 0);
                det_in = $urandom_range(0, 1);
                if (sample_en) begin
                    if (det_in) cnt++;
                    s++;
                end
                step();
            end
            sample_en = 1'b0; det_in = 1'b0;
            exp_q.push_back(cnt);
            check("rnd_valid", d_valid, 1);
            check("rnd_hits", d_hits, exp_q.pop_front());
            result_ready = 1'b1; step(); result_ready = 1'b0;
        end
        check("rnd_trials", d_trials, 256);
        check("rnd_wcnt", d_wcnt, 100);
        check("rnd_dropped", d_dropped, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
